// File: rtl/rx_deframer.sv
// rx_deframer: recovers framed payload bytes from the optical receiver's bit stream.
// A frame is a sync word, a length byte, 1..MAX_LEN payload bytes and an XOR checksum.
// The checksum covers the length byte and every payload byte. Payload bytes are
// forwarded as they arrive, so the downstream consumer must drop any frame that
// ends in frame_err.
module rx_deframer #(
  parameter logic [7:0] SYNC_WORD = 8'hD5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_err,
  output logic       busy
);

  // The idle counter only has to count up to TIMEOUT, so it is sized to exactly that.
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [7:0]      sreg, sreg_n;
  logic [3:0]      cnt, cnt_n;
  logic [7:0]      remaining, remaining_n;
  logic [7:0]      csum, csum_n;
  logic [IW-1:0]   idle, idle_n;
  logic            first, first_n;
  logic [7:0]      byte_out_n;
  logic            byte_valid_n;
  logic            frame_start_n;
  logic            frame_end_n;
  logic            frame_err_n;
  logic            busy_n;
  logic [7:0]      shifted;
  logic            to_hunt;

  // State and output registers; reset discards all frame progress silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      sreg        <= '0;
      cnt         <= '0;
      remaining   <= '0;
      csum        <= '0;
      idle        <= '0;
      first       <= 1'b0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      sreg        <= sreg_n;
      cnt         <= cnt_n;
      remaining   <= remaining_n;
      csum        <= csum_n;
      idle        <= idle_n;
      first       <= first_n;
      byte_out    <= byte_out_n;
      byte_valid  <= byte_valid_n;
      frame_start <= frame_start_n;
      frame_end   <= frame_end_n;
      frame_err   <= frame_err_n;
      busy        <= busy_n;
    end
  end

  // Next-state logic: sync hunt, length/payload/checksum parsing and the idle timeout.
  always_comb begin
    state_n       = state;
    sreg_n        = sreg;
    cnt_n         = cnt;
    remaining_n   = remaining;
    csum_n        = csum;
    idle_n        = idle;
    first_n       = first;
    byte_out_n    = byte_out;
    byte_valid_n  = 1'b0;
    frame_start_n = 1'b0;
    frame_end_n   = 1'b0;
    frame_err_n   = 1'b0;
    to_hunt       = 1'b0;
    shifted       = {sreg[6:0], bit_in};

    if (bit_valid) begin
      idle_n = '0;
    end else if (state != HUNT) begin
      idle_n = idle + IW'(1);
    end

    case (state)
      HUNT: begin
        if (bit_valid) begin
          sreg_n = shifted;
          cnt_n  = (cnt == 4'd8) ? 4'd8 : cnt + 4'd1;
          if (cnt_n == 4'd8 && shifted == SYNC_WORD) begin
            state_n = LEN;
            cnt_n   = '0;
          end
        end
      end

      LEN: begin
        if (bit_valid) begin
          sreg_n = shifted;
          if (cnt == 4'd7) begin
            cnt_n = '0;
            if (shifted == 8'd0 || shifted > MAX_LEN_B) begin
              frame_err_n = 1'b1;
              to_hunt     = 1'b1;
            end else begin
              remaining_n = shifted;
              csum_n      = shifted;
              first_n     = 1'b1;
              state_n     = PAYLOAD;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end

      PAYLOAD: begin
        if (bit_valid) begin
          sreg_n = shifted;
          if (cnt == 4'd7) begin
            cnt_n         = '0;
            byte_out_n    = shifted;
            byte_valid_n  = 1'b1;
            frame_start_n = first;
            first_n       = 1'b0;
            csum_n        = csum ^ shifted;
            remaining_n   = remaining - 8'd1;
            if (remaining == 8'd1) begin
              state_n = CHECK;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end

      CHECK: begin
        if (bit_valid) begin
          sreg_n = shifted;
          if (cnt == 4'd7) begin
            cnt_n = '0;
            if (shifted == csum) begin
              frame_end_n = 1'b1;
            end else begin
              frame_err_n = 1'b1;
            end
            to_hunt = 1'b1;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end

      default: begin
        to_hunt = 1'b1;
      end
    endcase

    // A bit arriving on the deadline cycle wins, so the timeout needs bit_valid low.
    if (state != HUNT && !bit_valid && idle == IDLE_LAST) begin
      frame_err_n = 1'b1;
      to_hunt     = 1'b1;
    end

    // Re-entering the hunt forgets all bits so a stale frame cannot produce a match.
    if (to_hunt) begin
      state_n = HUNT;
      sreg_n  = '0;
      cnt_n   = '0;
      idle_n  = '0;
      first_n = 1'b0;
    end

    busy_n = (state_n != HUNT);
  end

endmodule

// File: tb/tb_rx_deframer.sv
// tb_rx_deframer: directed frames against a frame-level model of the deframer.
module tb_rx_deframer;

  localparam int         T    = 20;
  localparam int         MAXL = 16;
  localparam logic [7:0] SYNC = 8'hD5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid, frame_start, frame_end, frame_err, busy;
  logic [7:0] byte_out0;
  logic       byte_valid0, frame_start0, frame_end0, frame_err0, busy0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_bit_cyc = 0;

  rx_deframer #(.SYNC_WORD(SYNC), .MAX_LEN(MAXL), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .frame_start(frame_start),
    .frame_end(frame_end), .frame_err(frame_err), .busy(busy)
  );

  rx_deframer #(.SYNC_WORD(8'h00), .MAX_LEN(MAXL), .TIMEOUT(T)) dut0 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .byte_out(byte_out0), .byte_valid(byte_valid0), .frame_start(frame_start0),
    .frame_end(frame_end0), .frame_err(frame_err0), .busy(busy0)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Frame-level model: sliding sync window, then a list of received bytes interpreted
  // as length, payload and checksum.
  bit         m_ready = 1'b0;
  bit         m_in_frame = 1'b0;
  int         m_hist = 0;
  int         m_hn = 0;
  int         m_idle = 0;
  int         m_acc = 0;
  int         m_nb = 0;
  int         m_bytes[$];
  logic [7:0] e_byte_out = 8'h00;
  logic       e_bv = 1'b0, e_fs = 1'b0, e_fe = 1'b0, e_ferr = 1'b0, e_busy = 1'b0;

  task automatic m_leave();
    m_in_frame = 1'b0;
    m_hist = 0;
    m_hn = 0;
    m_idle = 0;
  endtask

  // Advance the model on each clock edge from the driven inputs.
  always @(posedge clk) begin
    int k, len, x;
    e_bv = 1'b0; e_fs = 1'b0; e_fe = 1'b0; e_ferr = 1'b0;
    if (rst) begin
      m_leave();
      e_byte_out = 8'h00;
    end else if (bit_valid) begin
      m_idle = 0;
      if (!m_in_frame) begin
        m_hist = ((m_hist << 1) | int'(bit_in)) & 255;
        m_hn++;
        if (m_hn >= 8 && m_hist == int'(SYNC)) begin
          m_in_frame = 1'b1;
          m_bytes.delete();
          m_acc = 0;
          m_nb = 0;
        end
      end else begin
        m_acc = ((m_acc << 1) | int'(bit_in)) & 255;
        m_nb++;
        if (m_nb % 8 == 0) begin
          m_bytes.push_back(m_acc);
          k = m_bytes.size();
          len = m_bytes[0];
          if (k == 1) begin
            if (len == 0 || len > MAXL) begin
              e_ferr = 1'b1;
              m_leave();
            end
          end else if (k <= len + 1) begin
            e_bv = 1'b1;
            e_byte_out = 8'(m_acc);
            e_fs = (k == 2);
          end else begin
            x = 0;
            for (int i = 0; i < k - 1; i++) x ^= m_bytes[i];
            if (x == m_acc) e_fe = 1'b1;
            else e_ferr = 1'b1;
            m_leave();
          end
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == T) begin
        e_ferr = 1'b1;
        m_leave();
      end
    end
    e_busy = m_in_frame;
    m_ready = 1'b1;
  end

  task automatic checkOutput();
    cmp("byte_out", 32'(byte_out), 32'(e_byte_out));
    cmp("byte_valid", 32'(byte_valid), 32'(e_bv));
    cmp("frame_start", 32'(frame_start), 32'(e_fs));
    cmp("frame_end", 32'(frame_end), 32'(e_fe));
    cmp("frame_err", 32'(frame_err), 32'(e_ferr));
    cmp("busy", 32'(busy), 32'(e_busy));
  endtask

  // Compare the DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) checkOutput();
  end

  // Event log of DUT pulses for the literal per-scenario expectations.
  logic [7:0] lb[$];
  int n_start = 0, n_end = 0, n_err = 0;
  int start_byte = -1, end_cyc = -1, err_cyc = -1;

  always @(negedge clk) begin
    if (byte_valid === 1'b1) lb.push_back(byte_out);
    if (byte_valid === 1'b1 && frame_start === 1'b1) begin
      n_start++;
      start_byte = int'(byte_out);
    end
    if (frame_end === 1'b1) begin
      n_end++;
      if (end_cyc < 0) end_cyc = cyc;
    end
    if (frame_err === 1'b1) begin
      n_err++;
      if (err_cyc < 0) err_cyc = cyc;
    end
  end

  task automatic clearLog();
    lb.delete();
    n_start = 0; n_end = 0; n_err = 0;
    start_byte = -1; end_cyc = -1; err_cyc = -1;
  endtask

  function automatic logic [7:0] logByte(int i);
    return (lb.size() > i) ? lb[i] : 8'hxx;
  endfunction

  task automatic applyStimulus(input logic b, input logic v, input logic r);
    @(negedge clk);
    rst = r;
    bit_in = b;
    bit_valid = v;
    if (v && !r) last_bit_cyc = cyc;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(b[i], 1'b1, 1'b0);
      idleCycles(gap);
    end
  endtask

  task automatic sendFrame(input logic [7:0] chk, input int gap);
    sendByte(8'hD5, gap);
    sendByte(8'h02, gap);
    sendByte(8'hA5, gap);
    sendByte(8'h3C, gap);
    sendByte(chk, gap);
  endtask

  task automatic checkGoodFrame(input string tag);
    cmp({tag, "_nbytes"}, 32'(lb.size()), 32'd2);
    cmp({tag, "_byte0"}, 32'(logByte(0)), 32'hA5);
    cmp({tag, "_byte1"}, 32'(logByte(1)), 32'h3C);
    cmp({tag, "_start_byte"}, 32'(start_byte), 32'hA5);
    cmp({tag, "_n_start"}, 32'(n_start), 32'd1);
    cmp({tag, "_n_end"}, 32'(n_end), 32'd1);
    cmp({tag, "_n_err"}, 32'(n_err), 32'd0);
    cmp({tag, "_end_latency"}, 32'(end_cyc - last_bit_cyc), 32'd1);
  endtask

  initial begin
    // Reset.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    idleCycles(1);
    cmp("reset_busy", 32'(busy), 32'd0);
    cmp("reset_byte_out", 32'(byte_out), 32'd0);

    // Seven zeros must not lock onto an all-zero sync word; the eighth does.
    repeat (7) applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(2);
    cmp("sync00_seven_bits_busy", 32'(busy0), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(1);
    cmp("sync00_eight_bits_busy", 32'(busy0), 32'd1);
    idleCycles(T + 5);

    // Good frame, back-to-back bits.
    clearLog();
    sendFrame(8'h9B, 0);
    idleCycles(4);
    checkGoodFrame("good");

    // Bad checksum.
    clearLog();
    sendFrame(8'h9A, 0);
    idleCycles(4);
    cmp("badsum_nbytes", 32'(lb.size()), 32'd2);
    cmp("badsum_n_end", 32'(n_end), 32'd0);
    cmp("badsum_n_err", 32'(n_err), 32'd1);
    cmp("badsum_busy", 32'(busy), 32'd0);

    // Noise bits, then a good frame with a bit every fourth cycle.
    clearLog();
    applyStimulus(1'b1, 1'b1, 1'b0); idleCycles(3);
    applyStimulus(1'b0, 1'b1, 1'b0); idleCycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0); idleCycles(3);
    sendFrame(8'h9B, 3);
    idleCycles(4);
    cmp("sparse_nbytes", 32'(lb.size()), 32'd2);
    cmp("sparse_byte0", 32'(logByte(0)), 32'hA5);
    cmp("sparse_byte1", 32'(logByte(1)), 32'h3C);
    cmp("sparse_n_end", 32'(n_end), 32'd1);
    cmp("sparse_n_err", 32'(n_err), 32'd0);

    // Illegal lengths 0 and MAX_LEN+1, then a good frame.
    clearLog();
    sendByte(8'hD5, 0);
    sendByte(8'h00, 0);
    idleCycles(2);
    cmp("len0_n_err", 32'(n_err), 32'd1);
    cmp("len0_busy", 32'(busy), 32'd0);
    sendByte(8'hD5, 0);
    sendByte(8'h11, 0);
    idleCycles(2);
    cmp("len17_n_err", 32'(n_err), 32'd2);
    sendFrame(8'h9B, 0);
    idleCycles(4);
    cmp("len_recover_n_end", 32'(n_end), 32'd1);
    cmp("len_recover_nbytes", 32'(lb.size()), 32'd2);

    // Timeout after the first payload byte.
    clearLog();
    sendByte(8'hD5, 0);
    sendByte(8'h02, 0);
    sendByte(8'hA5, 0);
    idleCycles(T + 5);
    cmp("timeout_n_err", 32'(n_err), 32'd1);
    cmp("timeout_latency", 32'(err_cyc - last_bit_cyc), 32'(T + 1));
    cmp("timeout_busy", 32'(busy), 32'd0);

    // A bit on the deadline cycle keeps the frame alive.
    clearLog();
    sendByte(8'hD5, 0);
    sendByte(8'h02, 0);
    sendByte(8'hA5, 0);
    idleCycles(T - 1);
    sendByte(8'h3C, 0);
    sendByte(8'h9B, 0);
    idleCycles(4);
    cmp("deadline_n_err", 32'(n_err), 32'd0);
    cmp("deadline_n_end", 32'(n_end), 32'd1);

    // Reset mid-frame, then a clean frame.
    clearLog();
    sendByte(8'hD5, 0);
    sendByte(8'h02, 0);
    sendByte(8'hA5, 0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    idleCycles(1);
    cmp("midreset_busy", 32'(busy), 32'd0);
    cmp("midreset_byte_out", 32'(byte_out), 32'd0);
    cmp("midreset_n_err", 32'(n_err), 32'd0);
    clearLog();
    sendFrame(8'h9B, 0);
    idleCycles(4);
    checkGoodFrame("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
